// File: rtl/parking_floor_allocator_pkg.sv
// Shared types and width helpers for the parking floor allocator and its per-floor counters.
package parking_pkg;

    typedef enum logic {
        ALLOC_LOWEST,
        ALLOC_RR
    } alloc_policy_e;

    function automatic int floor_w(input int num_floors);
        return (num_floors < 2) ? 1 : $clog2(num_floors);
    endfunction

    function automatic int cnt_w(input int slots);
        return $clog2(slots + 1);
    endfunction

    function automatic int tot_w(input int num_floors, input int slots);
        return $clog2(num_floors * slots + 1);
    endfunction

endpackage

// File: rtl/parking_floor_allocator_counter.sv
// Saturating occupancy counter for one floor; a simultaneous legal inc and dec leave it unchanged.
module parking_floor_counter
    import parking_pkg::*;
#(
    parameter int CAP   = 4,
    parameter int CNT_W = cnt_w(CAP)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] occ,
    output logic             full,
    output logic             empty
);

    logic [CNT_W-1:0] occ_q;
    logic [CNT_W-1:0] occ_d;
    logic             inc_ok;
    logic             dec_ok;

    assign full  = (occ_q == CNT_W'(CAP));
    assign empty = (occ_q == '0);
    assign occ   = occ_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        inc_ok = inc && !full;
        dec_ok = dec && !empty;
        occ_d  = occ_q;
        if (inc_ok && !dec_ok) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (dec_ok && !inc_ok) begin
            occ_d = occ_q - CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

endmodule

// File: rtl/parking_floor_allocator.sv
// Stateful parking allocator: grants entries to a non-full floor (lowest-first or round-robin)
// and applies exits, with a one-cycle registered decision.
module parking_floor_allocator
    import parking_pkg::*;
#(
    parameter int            NUM_FLOORS      = 3,
    parameter int            SLOTS_PER_FLOOR = 4,
    parameter alloc_policy_e POLICY          = ALLOC_LOWEST
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          entry_req,
    input  logic                                          exit_req,
    input  logic [floor_w(NUM_FLOORS)-1:0]                exit_floor,
    output logic                                          grant_valid,
    output logic [NUM_FLOORS-1:0]                         grant_floor,
    output logic [floor_w(NUM_FLOORS)-1:0]                grant_idx,
    output logic [NUM_FLOORS-1:0]                         floor_full,
    output logic                                          full,
    output logic [tot_w(NUM_FLOORS, SLOTS_PER_FLOOR)-1:0] free_total,
    output logic                                          exit_err
);

    localparam int FLOOR_W = floor_w(NUM_FLOORS);
    localparam int CNT_W   = cnt_w(SLOTS_PER_FLOOR);
    localparam int TOT_W   = tot_w(NUM_FLOORS, SLOTS_PER_FLOOR);

    logic [CNT_W-1:0]      occ [NUM_FLOORS];
    logic [NUM_FLOORS-1:0] empty;
    logic [NUM_FLOORS-1:0] inc;
    logic [NUM_FLOORS-1:0] dec;

    logic                  grant_valid_q, grant_valid_d;
    logic [NUM_FLOORS-1:0] grant_floor_q, grant_floor_d;
    logic [FLOOR_W-1:0]    grant_idx_q,   grant_idx_d;
    logic [FLOOR_W-1:0]    rr_ptr_q,      rr_ptr_d;
    logic                  exit_err_q,    exit_err_d;

    logic [FLOOR_W:0]      pick_r;
    logic                  found;
    logic [FLOOR_W-1:0]    sel;
    logic [TOT_W-1:0]      occ_sum;

    // Returns {found, index}; RR searches from ptr+1 upward with wrap-around.
    function automatic logic [FLOOR_W:0] pick(input logic [NUM_FLOORS-1:0] fv,
                                              input logic [FLOOR_W-1:0]    ptr);
        logic               hit;
        logic [FLOOR_W-1:0] idx;
        int                 cand;
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < NUM_FLOORS; k++) begin
            cand = (POLICY == ALLOC_RR) ? (int'(ptr) + 1 + k) % NUM_FLOORS : k;
            if (!hit && !fv[cand]) begin
                hit = 1'b1;
                idx = FLOOR_W'(cand);
            end
        end
        return {hit, idx};
    endfunction

    for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_floor
        parking_floor_counter #(
            .CAP   (SLOTS_PER_FLOOR),
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc[g]),
            .dec   (dec[g]),
            .occ   (occ[g]),
            .full  (floor_full[g]),
            .empty (empty[g])
        );
    end

    always_comb begin
        pick_r        = pick(floor_full, rr_ptr_q);
        found         = pick_r[FLOOR_W];
        sel           = pick_r[FLOOR_W-1:0];
        inc           = '0;
        dec           = '0;
        occ_sum       = '0;
        grant_valid_d = entry_req;
        grant_floor_d = grant_floor_q;
        grant_idx_d   = grant_idx_q;
        rr_ptr_d      = rr_ptr_q;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            inc[i]  = entry_req && found && (sel == FLOOR_W'(i));
            dec[i]  = exit_req && (exit_floor == FLOOR_W'(i)) && !empty[i];
            occ_sum = occ_sum + TOT_W'(occ[i]);
        end
        // Out-of-range indices never match any floor, so they fall out as errors here.
        exit_err_d = exit_req && !(|dec);
        if (entry_req) begin
            grant_floor_d = found ? (NUM_FLOORS'(1) << sel) : '0;
            grant_idx_d   = found ? sel : '0;
            if (found && POLICY == ALLOC_RR) begin
                rr_ptr_d = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_valid_q <= 1'b0;
            grant_floor_q <= '0;
            grant_idx_q   <= '0;
            rr_ptr_q      <= FLOOR_W'(NUM_FLOORS - 1);
            exit_err_q    <= 1'b0;
        end else begin
            grant_valid_q <= grant_valid_d;
            grant_floor_q <= grant_floor_d;
            grant_idx_q   <= grant_idx_d;
            rr_ptr_q      <= rr_ptr_d;
            exit_err_q    <= exit_err_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_floor = grant_floor_q;
    assign grant_idx   = grant_idx_q;
    assign exit_err    = exit_err_q;
    assign full        = &floor_full;
    assign free_total  = TOT_W'(NUM_FLOORS * SLOTS_PER_FLOOR) - occ_sum;

endmodule

// File: tb/tb_parking_floor_allocator.sv
// Directed bench: lowest-first 3x4, round-robin 3x4 and lowest-first 5x1 allocators.
module tb_parking_floor_allocator;
    import parking_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Instance A: ALLOC_LOWEST, 3 floors x 4
    logic       a_entry = 0, a_exit = 0;
    logic [1:0] a_floor = '0;
    logic       a_gv, a_full, a_err;
    logic [2:0] a_gf, a_ff;
    logic [1:0] a_gi;
    logic [3:0] a_free;

    // Instance B: ALLOC_RR, 3 floors x 4
    logic       b_entry = 0, b_exit = 0;
    logic [1:0] b_floor = '0;
    logic       b_gv, b_full, b_err;
    logic [2:0] b_gf, b_ff;
    logic [1:0] b_gi;
    logic [3:0] b_free;

    // Instance C: ALLOC_LOWEST, 5 floors x 1
    logic       c_entry = 0, c_exit = 0;
    logic [2:0] c_floor = '0;
    logic       c_gv, c_full, c_err;
    logic [4:0] c_gf, c_ff;
    logic [2:0] c_gi;
    logic [2:0] c_free;

    parking_floor_allocator #(.NUM_FLOORS(3), .SLOTS_PER_FLOOR(4), .POLICY(ALLOC_LOWEST)) u_a (
        .clk(clk), .rst_n(rst_n), .entry_req(a_entry), .exit_req(a_exit), .exit_floor(a_floor),
        .grant_valid(a_gv), .grant_floor(a_gf), .grant_idx(a_gi), .floor_full(a_ff),
        .full(a_full), .free_total(a_free), .exit_err(a_err));

    parking_floor_allocator #(.NUM_FLOORS(3), .SLOTS_PER_FLOOR(4), .POLICY(ALLOC_RR)) u_b (
        .clk(clk), .rst_n(rst_n), .entry_req(b_entry), .exit_req(b_exit), .exit_floor(b_floor),
        .grant_valid(b_gv), .grant_floor(b_gf), .grant_idx(b_gi), .floor_full(b_ff),
        .full(b_full), .free_total(b_free), .exit_err(b_err));

    parking_floor_allocator #(.NUM_FLOORS(5), .SLOTS_PER_FLOOR(1), .POLICY(ALLOC_LOWEST)) u_c (
        .clk(clk), .rst_n(rst_n), .entry_req(c_entry), .exit_req(c_exit), .exit_floor(c_floor),
        .grant_valid(c_gv), .grant_floor(c_gf), .grant_idx(c_gi), .floor_full(c_ff),
        .full(c_full), .free_total(c_free), .exit_err(c_err));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_op(input logic en, input logic ex, input logic [1:0] fl);
        a_entry = en; a_exit = ex; a_floor = fl;
        tick();
        a_entry = 0; a_exit = 0; a_floor = '0;
    endtask

    task automatic b_op(input logic en, input logic ex, input logic [1:0] fl);
        b_entry = en; b_exit = ex; b_floor = fl;
        tick();
        b_entry = 0; b_exit = 0; b_floor = '0;
    endtask

    initial begin
        int rr_seq [8] = '{2, 0, 1, 2, 0, 1, 2, 1};

        tick();
        tick();
        rst_n = 1'b1;

        check("a_reset_gv",    a_gv,   0);
        check("a_reset_gf",    a_gf,   0);
        check("a_reset_gi",    a_gi,   0);
        check("a_reset_err",   a_err,  0);
        check("a_reset_ff",    a_ff,   0);
        check("a_reset_full",  a_full, 0);
        check("a_reset_free",  a_free, 12);
        check("b_reset_free",  b_free, 12);

        // Illegal exits: out-of-range floor, then empty floor 0.
        a_op(0, 1, 2'd3);
        check("ill_range_err",  a_err,  1);
        check("ill_range_free", a_free, 12);
        a_op(0, 0, 0);
        check("ill_err_pulse",  a_err,  0);
        a_op(0, 1, 2'd0);
        check("ill_empty_err",  a_err,  1);
        check("ill_empty_free", a_free, 12);
        a_op(0, 0, 0);
        check("ill_err_clear",  a_err,  0);

        // Lowest-first fill of 12 spaces.
        for (int i = 0; i < 12; i++) begin
            a_op(1, 0, 0);
            check($sformatf("low_gv%0d", i), a_gv, 1);
            check($sformatf("low_gf%0d", i), a_gf, 32'(3'b001 << (i / 4)));
        end
        check("low_full", a_full, 1);
        check("low_free", a_free, 0);
        a_op(1, 0, 0);
        check("low_rej_gv", a_gv, 1);
        check("low_rej_gf", a_gf, 0);
        check("low_rej_gi", a_gi, 0);
        a_op(0, 0, 0);
        check("low_idle_gv", a_gv, 0);

        // Full lot: exit on floor 2 with a same-cycle entry.
        a_op(1, 1, 2'd2);
        check("sim_gv",   a_gv,   1);
        check("sim_gf",   a_gf,   0);
        check("sim_free", a_free, 1);
        check("sim_ff",   a_ff,   3'b011);
        check("sim_err",  a_err,  0);
        a_op(1, 0, 0);
        check("sim_next_gf", a_gf, 3'b100);
        check("sim_next_gi", a_gi, 2);
        check("sim_next_full", a_full, 1);

        // Round-robin: first five grants.
        for (int i = 0; i < 5; i++) begin
            b_op(1, 0, 0);
            check($sformatf("rr_gi%0d", i), b_gi, 32'(i % 3));
        end
        b_op(0, 0, 0);
        check("rr_idle_gv", b_gv, 0);
        check("rr_hold_gi", b_gi, 1);
        check("rr_hold_gf", b_gf, 3'b010);
        b_op(0, 1, 2'd1);
        check("rr_exit_err",  b_err,  0);
        check("rr_exit_free", b_free, 8);
        for (int i = 0; i < 8; i++) begin
            b_op(1, 0, 0);
            check($sformatf("rr_fill_gi%0d", i), b_gi, 32'(rr_seq[i]));
        end
        check("rr_full", b_full, 1);
        b_op(1, 0, 0);
        check("rr_rej_gf", b_gf, 0);
        check("rr_rej_gi", b_gi, 0);

        // Reset mid-operation with a concurrent entry.
        b_op(0, 1, 2'd0);
        check("mid_free_pre", b_free, 1);
        rst_n = 1'b0;
        b_entry = 1;
        tick();
        b_entry = 0;
        rst_n = 1'b1;
        check("mid_rst_gv",   b_gv,   0);
        check("mid_rst_free", b_free, 12);
        b_op(1, 0, 0);
        check("mid_first_gf", b_gf, 3'b001);
        check("mid_first_gi", b_gi, 0);
        b_op(1, 0, 0);
        check("mid_second_gi", b_gi, 1);

        // 5 floors x 1 slot, back-to-back entries.
        c_entry = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("b2b_gv%0d", i), c_gv, 1);
            check($sformatf("b2b_gf%0d", i), c_gf, (i < 5) ? 32'(5'b00001 << i) : 32'd0);
        end
        c_entry = 0;
        check("b2b_full", c_full, 1);
        check("b2b_free", c_free, 0);
        tick();
        check("b2b_idle_gv", c_gv, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
